// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Merges per-stage stall requests, sequences exception/ERET redirects
// (deferring them while an instruction fetch is outstanding) and runs a
// stall watchdog with a sticky error flag.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
    parameter int          STALL_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_valid,
    input  logic        exc_eret,
    input  logic [31:0] cp0_epc,
    input  logic        ifetch_busy,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        new_pc_valid,
    output logic        watchdog_err
);

    localparam int              WD_W   = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

    // Freezing PC through MEM lets WB drain while the redirect is pending.
    localparam logic [5:0] STALL_ALL = 6'b011111;

    typedef enum logic {
        IDLE,
        WAIT_FETCH
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       tgt_q;
    logic [31:0]       target;
    logic              tgt_load;
    logic [5:0]        stall_req;
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_next;

    // Merge stage requests: the oldest stalling stage freezes everything younger.
    always_comb begin
        stall_req = 6'b000000;
        if (stallreq_mem)
            stall_req = 6'b011111;
        else if (stallreq_ex)
            stall_req = 6'b001111;
        else if (stallreq_id)
            stall_req = 6'b000111;
        else if (stallreq_if)
            stall_req = 6'b000011;
    end

    // Redirect target: an exception outranks a simultaneous ERET.
    always_comb begin
        target = exc_valid ? EXC_VECTOR : cp0_epc;
    end

    // Redirect sequencing and output decode; flush always forces stall to zero.
    always_comb begin
        state_next   = state;
        stall        = stall_req;
        flush        = 1'b0;
        new_pc_valid = 1'b0;
        new_pc       = 32'h0;
        tgt_load     = 1'b0;
        case (state)
            IDLE: begin
                if (exc_valid || exc_eret) begin
                    if (ifetch_busy) begin
                        tgt_load   = 1'b1;
                        stall      = STALL_ALL;
                        state_next = WAIT_FETCH;
                    end else begin
                        stall        = 6'b000000;
                        flush        = 1'b1;
                        new_pc_valid = 1'b1;
                        new_pc       = target;
                    end
                end
            end
            WAIT_FETCH: begin
                if (ifetch_busy) begin
                    stall = STALL_ALL;
                end else begin
                    stall        = 6'b000000;
                    flush        = 1'b1;
                    new_pc_valid = 1'b1;
                    new_pc       = tgt_q;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (reset) begin
            stall        = 6'b000000;
            flush        = 1'b0;
            new_pc_valid = 1'b0;
            new_pc       = 32'h0;
            tgt_load     = 1'b0;
            state_next   = IDLE;
        end
    end

    // State register; reset drops any pending redirect without a flush.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Capture the redirect target when the redirect has to wait for the fetch.
    always_ff @(posedge clk) begin
        if (reset)
            tgt_q <= 32'h0;
        else if (tgt_load)
            tgt_q <= target;
    end

    // Watchdog count: saturating run length of consecutive stalled cycles.
    always_comb begin
        if (stall == 6'b000000)
            wd_next = '0;
        else if (wd_cnt == WD_MAX)
            wd_next = wd_cnt;
        else
            wd_next = wd_cnt + WD_W'(1);
    end

    // Watchdog register and sticky error, set as the count reaches the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt       <= '0;
            watchdog_err <= 1'b0;
        end else begin
            wd_cnt <= wd_next;
            if (wd_next == WD_MAX)
                watchdog_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the stimulus process drives one
// directed vector per cycle and queues its hand-computed expected outputs;
// a monitor on the falling edge pops and compares.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        exc_valid, exc_eret;
    logic [31:0] cp0_epc;
    logic        ifetch_busy;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        new_pc_valid;
    logic        watchdog_err;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        vld;
        logic        wd;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    pipeline_ctrl #(
        .EXC_VECTOR   (32'hBFC00380),
        .STALL_TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stallreq_if (stallreq_if),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .exc_valid   (exc_valid),
        .exc_eret    (exc_eret),
        .cp0_epc     (cp0_epc),
        .ifetch_busy (ifetch_busy),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .new_pc_valid(new_pc_valid),
        .watchdog_err(watchdog_err)
    );

    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (stall !== e.stall || flush !== e.flush || new_pc !== e.pc ||
                new_pc_valid !== e.vld || watchdog_err !== e.wd) begin
                n_err++;
                $display("FAIL %s: got stall=%b flush=%b new_pc=%h vld=%b wd=%b, expected stall=%b flush=%b new_pc=%h vld=%b wd=%b",
                         e.name, stall, flush, new_pc, new_pc_valid, watchdog_err,
                         e.stall, e.flush, e.pc, e.vld, e.wd);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected outputs for that cycle.
    task automatic step(input logic rst, input logic [3:0] req, input logic ev,
                        input logic er, input logic [31:0] epc, input logic busy,
                        input logic [5:0] e_stall, input logic e_flush,
                        input logic [31:0] e_pc, input logic e_vld, input logic e_wd,
                        input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        stallreq_mem = req[3];
        stallreq_ex  = req[2];
        stallreq_id  = req[1];
        stallreq_if  = req[0];
        exc_valid    = ev;
        exc_eret     = er;
        cp0_epc      = epc;
        ifetch_busy  = busy;
        e.stall = e_stall;
        e.flush = e_flush;
        e.pc    = e_pc;
        e.vld   = e_vld;
        e.wd    = e_wd;
        e.name  = name;
        sb_q.push_back(e);
    endtask

    localparam logic [31:0] EV = 32'hBFC00380;

    initial begin
        reset = 1'b1;
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0;
        exc_valid = 1'b0; exc_eret = 1'b0; cp0_epc = 32'h0; ifetch_busy = 1'b0;
        repeat (2) @(posedge clk);

        //    rst  {mem,ex,id,if} ev er epc           busy  stall      fl pc            v  wd
        step(1'b1, 4'b1000, 1'b1, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 32'h0,        0, 0, "reset_gate");
        step(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 32'h0,        0, 0, "reset_idle");
        // stall merge
        step(1'b0, 4'b0010, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000111, 0, 32'h0,        0, 0, "stall_id");
        step(1'b0, 4'b1010, 1'b0, 1'b0, 32'h0,        1'b0, 6'b011111, 0, 32'h0,        0, 0, "stall_id_mem");
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 32'h0,        0, 0, "stall_release");
        step(1'b0, 4'b0001, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000011, 0, 32'h0,        0, 0, "stall_if");
        step(1'b0, 4'b0101, 1'b0, 1'b0, 32'h0,        1'b0, 6'b001111, 0, 32'h0,        0, 0, "stall_ex_if");
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 32'h0,        0, 0, "stall_none");
        // direct exception redirect
        step(1'b0, 4'b0010, 1'b1, 1'b0, 32'h0,        1'b0, 6'b000000, 1, EV,           1, 0, "exc_direct");
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 32'h0,        0, 0, "exc_after");
        // ERET deferred by a busy fetch; epc changes and requests during the wait are ignored
        step(1'b0, 4'b0000, 1'b0, 1'b1, 32'h80001234, 1'b1, 6'b011111, 0, 32'h0,        0, 0, "eret_wait1");
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 6'b011111, 0, 32'h0,        0, 0, "eret_wait2");
        step(1'b0, 4'b0010, 1'b1, 1'b0, 32'h0,        1'b1, 6'b011111, 0, 32'h0,        0, 0, "eret_wait3");
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000000, 1, 32'h80001234, 1, 0, "eret_flush");
        // priority, then back-to-back redirect
        step(1'b0, 4'b0000, 1'b1, 1'b1, 32'h1,        1'b0, 6'b000000, 1, EV,           1, 0, "exc_priority");
        step(1'b0, 4'b0000, 1'b0, 1'b1, 32'h00000040, 1'b0, 6'b000000, 1, 32'h00000040, 1, 0, "back_to_back");
        // reset while waiting for the fetch
        step(1'b0, 4'b0000, 1'b1, 1'b0, 32'h0,        1'b1, 6'b011111, 0, 32'h0,        0, 0, "wf_enter");
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 6'b011111, 0, 32'h0,        0, 0, "wf_hold");
        step(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 6'b000000, 0, 32'h0,        0, 0, "wf_reset");
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 32'h0,        0, 0, "wf_no_flush");
        // fetch completes in the same cycle the exception arrives
        step(1'b0, 4'b0000, 1'b1, 1'b0, 32'h0,        1'b0, 6'b000000, 1, EV,           1, 0, "busy_drop_exc");
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 32'h0,        0, 0, "busy_drop_after");
        // watchdog with a limit of 4 stalled cycles
        step(1'b0, 4'b0100, 1'b0, 1'b0, 32'h0,        1'b0, 6'b001111, 0, 32'h0,        0, 0, "wd_stall1");
        step(1'b0, 4'b0100, 1'b0, 1'b0, 32'h0,        1'b0, 6'b001111, 0, 32'h0,        0, 0, "wd_stall2");
        step(1'b0, 4'b0100, 1'b0, 1'b0, 32'h0,        1'b0, 6'b001111, 0, 32'h0,        0, 0, "wd_stall3");
        step(1'b0, 4'b0100, 1'b0, 1'b0, 32'h0,        1'b0, 6'b001111, 0, 32'h0,        0, 0, "wd_stall4");
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 32'h0,        0, 1, "wd_set");
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 32'h0,        0, 1, "wd_sticky");
        step(1'b0, 4'b0100, 1'b0, 1'b0, 32'h0,        1'b0, 6'b001111, 0, 32'h0,        0, 1, "wd_sticky_stall");
        step(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 32'h0,        0, 1, "wd_reset_cycle");
        step(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 6'b000000, 0, 32'h0,        0, 0, "wd_cleared");

        // Let the monitor drain the queue, bounded.
        begin
            int guard;
            guard = 0;
            while (sb_q.size() > 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            if (sb_q.size() > 0) begin
                n_err++;
                $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
